// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared types for the flash ROM arbiter.
//   flash_port_e : requester id (fetch = 0, load = 1)
//   flash_ifl_t  : in-flight tracker entry {vld, id}
package flash_arb_pkg;

  typedef enum logic {
    FLASH_PORT_IF = 1'b0,
    FLASH_PORT_LS = 1'b1
  } flash_port_e;

  typedef struct packed {
    logic        vld;
    flash_port_e id;
  } flash_ifl_t;

endpackage

// File: rtl/flash_arb_track.sv
// flash_arb_track: DEPTH-deep {valid, port id} delay line that follows each
// granted ROM read until its data appears on rom_data.
//   clk, rst           : clock, async active-high clear (all entries invalid)
//   push_vld, push_id  : entry entering this cycle (push_vld=0 for no grant)
//   pop_vld, pop_id    : entry emerging DEPTH cycles after its push
module flash_arb_track
  import flash_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_vld,
  input  logic push_id,
  output logic pop_vld,
  output logic pop_id
);

  flash_ifl_t [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d        = pipe_q;
    pipe_d[0].vld = push_vld;
    pipe_d[0].id  = flash_port_e'(push_id);
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign pop_vld = pipe_q[DEPTH-1].vld;
  assign pop_id  = pipe_q[DEPTH-1].id;

endmodule

// File: rtl/flash_arb.sv
// flash_arb: shares a single-ported flash ROM between the fetch (if_*) and
// load (ls_*) ports. One grant per cycle; each read returns on its own port
// exactly ROM_LAT cycles after the grant.
//   clk, rst                              : clock, async active-high reset
//   if_req_vld/rdy/addr, if_rsp_vld/data  : fetch port
//   ls_req_vld/rdy/addr, ls_rsp_vld/data  : load port
//   rom_en, rom_addr, rom_data            : ROM read port (data after ROM_LAT)
// Build option: define FLASH_ARB_FIXED_PRIO_EN for fetch-always-wins
// priority; otherwise conflicts are resolved round-robin.
module flash_arb
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ROM_AW  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_vld,
  output logic              if_req_rdy,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_vld,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_vld,
  output logic              ls_req_rdy,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_rsp_vld,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic gnt_if, gnt_ls;
  logic pop_vld, pop_id;

`ifdef FLASH_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_if = if_req_vld & ~rst;
    gnt_ls = ls_req_vld & ~if_req_vld & ~rst;
  end
`else
  // last_q holds the most recently granted port; the other one wins a
  // conflict. Reset to LS so fetch wins the first conflict.
  flash_port_e last_q, last_d;

  always_comb begin
    gnt_ls = ls_req_vld & (~if_req_vld | (last_q == FLASH_PORT_IF)) & ~rst;
    gnt_if = if_req_vld & ~gnt_ls & ~rst;
    last_d = last_q;
    if (gnt_if | gnt_ls) last_d = gnt_ls ? FLASH_PORT_LS : FLASH_PORT_IF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= FLASH_PORT_LS;
    else     last_q <= last_d;
  end
`endif

  assign if_req_rdy = gnt_if;
  assign ls_req_rdy = gnt_ls;
  assign rom_en     = gnt_if | gnt_ls;
  // Byte address -> word address; low byte offset and high bits alias.
  assign rom_addr   = gnt_ls ? ls_req_addr[ROM_AW+1:2] : if_req_addr[ROM_AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[1:0], if_req_addr[ADDR_W-1:ROM_AW+2],
                              ls_req_addr[1:0], ls_req_addr[ADDR_W-1:ROM_AW+2]};

  flash_arb_track #(.DEPTH(ROM_LAT)) u_track (
    .clk      (clk),
    .rst      (rst),
    .push_vld (gnt_if | gnt_ls),
    .push_id  (gnt_ls),
    .pop_vld  (pop_vld),
    .pop_id   (pop_id)
  );

  // ROM data is broadcast; only the port whose id emerges sees rsp_vld.
  assign if_rsp_vld  = pop_vld & (pop_id == FLASH_PORT_IF);
  assign ls_rsp_vld  = pop_vld & (pop_id == FLASH_PORT_LS);
  assign if_rsp_data = rom_data;
  assign ls_rsp_data = rom_data;

endmodule

// File: tb/tb_flash_arb.sv
// tb_flash_arb: self-checking bench for flash_arb with ROM_LAT=2. A ROM model
// supplies data; a reference model (arbitration rule + expected-response
// queue ordered by due cycle) predicts grants, addresses and responses.
module tb_flash_arb;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_vld = 1'b0, ls_req_vld = 1'b0;
  logic [31:0] if_req_addr = '0, ls_req_addr = '0;
  logic        if_req_rdy, ls_req_rdy, if_rsp_vld, ls_rsp_vld, rom_en;
  logic [31:0] if_rsp_data, ls_rsp_data, rom_data;
  logic [11:0] rom_addr;

  flash_arb #(.ADDR_W(32), .DATA_W(32), .ROM_AW(12), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_vld(if_req_vld), .if_req_rdy(if_req_rdy), .if_req_addr(if_req_addr),
    .if_rsp_vld(if_rsp_vld), .if_rsp_data(if_rsp_data),
    .ls_req_vld(ls_req_vld), .ls_req_rdy(ls_req_rdy), .ls_req_addr(ls_req_addr),
    .ls_rsp_vld(ls_rsp_vld), .ls_rsp_data(ls_rsp_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int idx);
    logic [31:0] v;
    v = idx;
    return (v * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ROM model: fixed LAT-cycle read pipeline.
  logic [31:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? rom_word(int'(rom_addr)) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  // Reference model state
  typedef struct { int due; bit port; logic [31:0] data; } exp_t;
  exp_t q[$];
  bit   m_last;        // last granted port (1 = load)
  int   cyc;
  int   n_tests = 0, n_fail = 0;
  bit   e_gif, e_gls, e_ifv, e_lsv;
  logic [11:0] e_addr;
  logic [31:0] e_ifd, e_lsd;

  task automatic drive(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la);
    if_req_vld = iv; if_req_addr = ia; ls_req_vld = lv; ls_req_addr = la;
  endtask

  task automatic predict();
    e_gif = 0; e_gls = 0; e_ifv = 0; e_lsv = 0; e_ifd = 'x; e_lsd = 'x;
    if (if_req_vld && ls_req_vld) begin
`ifdef FLASH_ARB_FIXED_PRIO_EN
      e_gif = 1;
`else
      if (m_last) e_gif = 1; else e_gls = 1;
`endif
    end else begin
      e_gif = if_req_vld; e_gls = ls_req_vld;
    end
    e_addr = e_gls ? ls_req_addr[13:2] : if_req_addr[13:2];
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].port) begin e_lsv = 1; e_lsd = q[0].data; end
      else           begin e_ifv = 1; e_ifd = q[0].data; end
    end
  endtask

  task automatic advance();
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (e_gif || e_gls) begin
      q.push_back('{cyc + LAT, e_gls, rom_word(int'(e_addr))});
      m_last = e_gls;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_last = 1; cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 32'h10, 1, 32'h20);
    @(negedge clk);
    n_tests++;
    if ({if_req_rdy, ls_req_rdy, rom_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_req got rdy/en=%b want 000", {if_req_rdy, ls_req_rdy, rom_en});
    end
    n_tests++;
    if ({if_rsp_vld, ls_rsp_vld} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp got %b want 00", {if_rsp_vld, ls_rsp_vld});
    end
    @(posedge clk); #1;
    apply_reset();
  endtask

  task automatic test_fetch_only();
    apply_reset();
    for (int k = 0; k < 3 + LAT; k++) begin
      if (k < 3) drive(1, 32'(4 * k), 0, 0); else drive(0, 0, 0, 0);
      @(negedge clk); predict();
      n_tests++;
      if ({if_req_rdy, ls_req_rdy, rom_en} !== {e_gif, e_gls, e_gif | e_gls} || (k < 3 && if_req_rdy !== 1'b1)) begin
        n_fail++; $display("FAIL fetch_gnt c%0d got %b want %b", k, {if_req_rdy, ls_req_rdy, rom_en}, {e_gif, e_gls, e_gif | e_gls});
      end
      if (k < 3) begin
        n_tests++;
        if (rom_addr !== 12'(k)) begin
          n_fail++; $display("FAIL fetch_addr c%0d got %h want %h", k, rom_addr, 12'(k));
        end
      end
      n_tests++;
      if ({if_rsp_vld, ls_rsp_vld} !== {e_ifv, 1'b0} || (e_ifv && if_rsp_data !== e_ifd)) begin
        n_fail++; $display("FAIL fetch_rsp c%0d got %b/%h want %b/%h", k, {if_rsp_vld, ls_rsp_vld}, if_rsp_data, {e_ifv, 1'b0}, e_ifd);
      end
      advance();
    end
  endtask

  task automatic test_conflict();
    bit exp_if;
    apply_reset();
    for (int k = 0; k < 5 + LAT; k++) begin
      if (k < 4) drive(1, 32'h10, 1, 32'h20);
      else if (k == 4) drive(0, 0, 1, 32'h20);
      else drive(0, 0, 0, 0);
      @(negedge clk); predict();
`ifdef FLASH_ARB_FIXED_PRIO_EN
      exp_if = (k < 4);
`else
      exp_if = (k < 4) && (k % 2 == 0);
`endif
      n_tests++;
      if ({if_req_rdy, ls_req_rdy} !== {e_gif, e_gls} || (k < 5 && if_req_rdy !== exp_if)) begin
        n_fail++; $display("FAIL conflict_gnt c%0d got %b want %b", k, {if_req_rdy, ls_req_rdy}, {e_gif, e_gls});
      end
      if (e_gif | e_gls) begin
        n_tests++;
        if (rom_addr !== (e_gls ? 12'd8 : 12'd4)) begin
          n_fail++; $display("FAIL conflict_addr c%0d got %h want %h", k, rom_addr, e_gls ? 12'd8 : 12'd4);
        end
      end
      n_tests++;
      if ({if_rsp_vld, ls_rsp_vld} !== {e_ifv, e_lsv} ||
          (e_ifv && if_rsp_data !== e_ifd) || (e_lsv && ls_rsp_data !== e_lsd)) begin
        n_fail++; $display("FAIL conflict_rsp c%0d got %b want %b", k, {if_rsp_vld, ls_rsp_vld}, {e_ifv, e_lsv});
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 3 + LAT; k++) begin
      case (k)
        0: drive(1, 32'h0, 0, 0);
        1: drive(0, 0, 1, 32'h4);
        2: drive(1, 32'h8, 0, 0);
        default: drive(0, 0, 0, 0);
      endcase
      @(negedge clk); predict();
      n_tests++;
      if ({if_req_rdy, ls_req_rdy, rom_en} !== {e_gif, e_gls, e_gif | e_gls}) begin
        n_fail++; $display("FAIL b2b_gnt c%0d got %b want %b", k, {if_req_rdy, ls_req_rdy, rom_en}, {e_gif, e_gls, e_gif | e_gls});
      end
      n_tests++;
      if ({if_rsp_vld, ls_rsp_vld} !== {e_ifv, e_lsv} ||
          (e_ifv && if_rsp_data !== e_ifd) || (e_lsv && ls_rsp_data !== e_lsd) ||
          (k >= LAT && k < LAT + 3 && (e_ifv ? if_rsp_data : ls_rsp_data) !== rom_word(k - LAT))) begin
        n_fail++; $display("FAIL b2b_rsp c%0d got %b/%h/%h want %b word %0d", k, {if_rsp_vld, ls_rsp_vld}, if_rsp_data, ls_rsp_data, {e_ifv, e_lsv}, k - LAT);
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    drive(1, 32'h0, 0, 0);
    @(negedge clk); predict();
    n_tests++;
    if (if_req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gnt got %b want 1", if_req_rdy);
    end
    advance();
    drive(0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    n_tests++;
    if ({if_rsp_vld, ls_rsp_vld, if_req_rdy, ls_req_rdy} !== 4'b0) begin
      n_fail++; $display("FAIL midrst_during got %b want 0000", {if_rsp_vld, ls_rsp_vld, if_req_rdy, ls_req_rdy});
    end
    @(posedge clk); #1;
    rst = 0; q.delete(); m_last = 1; cyc = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      n_tests++;
      if ({if_rsp_vld, ls_rsp_vld} !== 2'b00) begin
        n_fail++; $display("FAIL midrst_rsp c%0d got %b want 00", k, {if_rsp_vld, ls_rsp_vld});
      end
      @(posedge clk); #1; cyc++;
    end
    drive(1, 32'h40, 1, 32'h80);
    @(negedge clk); predict();
    n_tests++;
    if ({if_req_rdy, ls_req_rdy} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_prio got %b want 10", {if_req_rdy, ls_req_rdy});
    end
    advance();
    apply_reset();
  endtask

  task automatic test_alias();
    apply_reset();
    for (int k = 0; k < 1 + LAT; k++) begin
      if (k == 0) drive(1, 32'h4003, 0, 0); else drive(0, 0, 0, 0);
      @(negedge clk); predict();
      if (k == 0) begin
        n_tests++;
        if (rom_en !== 1'b1 || rom_addr !== 12'h000) begin
          n_fail++; $display("FAIL alias_addr got en=%b %h want 1 000", rom_en, rom_addr);
        end
      end
      if (k == LAT) begin
        n_tests++;
        if (if_rsp_vld !== 1'b1 || if_rsp_data !== rom_word(0)) begin
          n_fail++; $display("FAIL alias_rsp got %b/%h want 1/%h", if_rsp_vld, if_rsp_data, rom_word(0));
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit iv, lv;
    logic [31:0] ia, la;
    int errs = 0;
    apply_reset();
    iv = 0; lv = 0; ia = 0; la = 0;
    for (int k = 0; k < 400 + LAT; k++) begin
      if (k < 400) begin
        // Requests hold vld/addr until granted, with occasional random drops.
        if (!iv || if_req_rdy || $urandom_range(0, 7) == 0) begin iv = $urandom_range(0, 1); ia = $urandom; end
        if (!lv || ls_req_rdy || $urandom_range(0, 7) == 0) begin lv = $urandom_range(0, 1); la = $urandom; end
      end else begin
        iv = 0; lv = 0;
      end
      drive(iv, ia, lv, la);
      @(negedge clk); predict();
      n_tests++;
      if ({if_req_rdy, ls_req_rdy, rom_en} !== {e_gif, e_gls, e_gif | e_gls} ||
          ((e_gif | e_gls) && rom_addr !== e_addr) ||
          {if_rsp_vld, ls_rsp_vld} !== {e_ifv, e_lsv} ||
          (e_ifv && if_rsp_data !== e_ifd) || (e_lsv && ls_rsp_data !== e_lsd)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random c%0d got gnt=%b addr=%h rsp=%b want gnt=%b addr=%h rsp=%b", k,
                   {if_req_rdy, ls_req_rdy, rom_en}, rom_addr, {if_rsp_vld, ls_rsp_vld},
                   {e_gif, e_gls, e_gif | e_gls}, e_addr, {e_ifv, e_lsv});
      end
      // Capture grant for this cycle's hold decision (sampled before edge).
      iv = iv & ~if_req_rdy ? iv : (if_req_rdy ? 1'b0 : iv);
      lv = lv & ~ls_req_rdy ? lv : (ls_req_rdy ? 1'b0 : lv);
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_conflict();
    test_back_to_back();
    test_reset_midflight();
    test_alias();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
